// File: rtl/button_conditioner_if.sv
// Button-side bundle: raw asynchronous button levels in, conditioned
// note levels and one-hot navigation press pulses out.
interface button_conditioner_if #(
  parameter int N_NOTES = 8
);
  logic [N_NOTES-1:0] raw_notes;
  logic               raw_up;
  logic               raw_center;
  logic               raw_down;
  logic [N_NOTES-1:0] notes;
  logic               up_pulse;
  logic               center_pulse;
  logic               down_pulse;

  modport master (
    output raw_notes, raw_up, raw_center, raw_down,
    input  notes, up_pulse, center_pulse, down_pulse
  );

  modport slave (
    input  raw_notes, raw_up, raw_center, raw_down,
    output notes, up_pulse, center_pulse, down_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces note and navigation buttons; navigation presses
// become single-cycle pulses, arbitrated center > up > down.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int N_NOTES         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  btn
);

  localparam int NCH    = N_NOTES + 3;
  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int UP     = N_NOTES;
  localparam int CENTER = N_NOTES + 1;
  localparam int DOWN   = N_NOTES + 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] s1;
  logic [NCH-1:0] s2;
  logic [NCH-1:0] stb;
  logic [NCH-1:0] stb_next;
  logic [CW-1:0]  cnt      [NCH];
  logic [CW-1:0]  cnt_next [NCH];
  logic [2:0]     nav_rise;
  logic           up_win;
  logic           center_win;
  logic           down_win;
  logic           up_q;
  logic           center_q;
  logic           down_q;

  assign raw_all = {btn.raw_down, btn.raw_center, btn.raw_up, btn.raw_notes};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_all;
      s2 <= s1;
    end
  end

  // Any sample matching the accepted level restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
  always_comb begin
    stb_next = stb;
    for (int c = 0; c < NCH; c++) begin
      cnt_next[c] = '0;
      if (s2[c] != stb[c]) begin
        if (cnt[c] == CNT_MAX) begin
          stb_next[c] = s2[c];
        end else begin
          cnt_next[c] = cnt[c] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb <= '0;
      for (int c = 0; c < NCH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      stb <= stb_next;
      for (int c = 0; c < NCH; c++) begin
        cnt[c] <= cnt_next[c];
      end
    end
  end

  // Losing rises are dropped outright; their stable level still updates.
  assign nav_rise   = stb_next[DOWN:UP] & ~stb[DOWN:UP];
  assign center_win = nav_rise[CENTER-UP];
  assign up_win     = nav_rise[0] & ~nav_rise[CENTER-UP];
  assign down_win   = nav_rise[DOWN-UP] & ~nav_rise[CENTER-UP] & ~nav_rise[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_q     <= 1'b0;
      center_q <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      up_q     <= up_win;
      center_q <= center_win;
      down_q   <= down_win;
    end
  end

  assign btn.notes        = stb[N_NOTES-1:0];
  assign btn.up_pulse     = up_q;
  assign btn.center_pulse = center_q;
  assign btn.down_pulse   = down_q;

endmodule
